vga_scanout: RTL

//  Reads the 320x240, 6-bit-per-pixel frame buffer written by the map and sprite drawers.

---
 rtl/vga_pkg.sv | 76 +++++++
 rtl/vga_timing_gen.sv | 51 +++++
 rtl/vga_scanout.sv | 117 +++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: 640x480@60 timing, 320x240 frame-buffer geometry and colour helpers.
// SCANOUT_TEST_PATTERN_EN (seen by vga_scanout) replaces frame-buffer colour with bars.
`timescale 1ns/1ps
package vga_pkg;

    localparam int CNT_W = 10;
    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t H_VIS   = 10'd640;
    localparam cnt_t H_FP    = 10'd16;
    localparam cnt_t H_SYNC  = 10'd96;
    localparam cnt_t H_BP    = 10'd48;
    localparam cnt_t H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam cnt_t H_SYNC_START = H_VIS + H_FP;
    localparam cnt_t H_SYNC_END   = H_SYNC_START + H_SYNC;

    localparam cnt_t V_VIS   = 10'd480;
    localparam cnt_t V_FP    = 10'd10;
    localparam cnt_t V_SYNC  = 10'd2;
    localparam cnt_t V_BP    = 10'd33;
    localparam cnt_t V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
    localparam cnt_t V_SYNC_START = V_VIS + V_FP;
    localparam cnt_t V_SYNC_END   = V_SYNC_START + V_SYNC;

    localparam int FB_W     = 320;
    localparam int FB_H     = 240;
    localparam int FB_DEPTH = FB_W * FB_H;
    localparam int ADDR_W   = $clog2(FB_DEPTH);
    localparam int COLOUR_W = 6;

    typedef logic [ADDR_W-1:0]   addr_t;
    typedef logic [COLOUR_W-1:0] colour_t;
    typedef logic [8:0]          fb_x_t;
    typedef logic [7:0]          fb_y_t;

    localparam int R_HI = 5;
    localparam int R_LO = 4;
    localparam int G_HI = 3;
    localparam int G_LO = 2;
    localparam int B_HI = 1;
    localparam int B_LO = 0;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef struct packed {
        logic vis;
        logic hs;
        logic vs;
    } sync_t;

    localparam sync_t SYNC_IDLE = '{vis: 1'b0, hs: 1'b1, vs: 1'b1};

    function automatic logic [7:0] expand2(input logic [1:0] c);
        return {4{c}};
    endfunction

    function automatic rgb_t expand(input colour_t c);
        rgb_t p;
        p.r = expand2(c[R_HI:R_LO]);
        p.g = expand2(c[G_HI:G_LO]);
        p.b = expand2(c[B_HI:B_LO]);
        return p;
    endfunction

    // y*320 as y*256 + y*64 keeps the address path multiplier-free
    function automatic addr_t fb_addr(input fb_x_t x, input fb_y_t y);
        addr_t yy;
        yy = addr_t'(y);
        return (yy << 8) + (yy << 6) + addr_t'(x);
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: free-running h/v counters and the stage-0 visibility/sync terms.
// Frame-buffer coordinates come out already halved for pixel doubling.
`timescale 1ns/1ps
module vga_timing_gen
    import vga_pkg::*;
(
    input  logic       clock,
    input  logic       resetn,
    output fb_x_t      x0,
    output fb_y_t      y0,
    output logic [2:0] bar0,
    output logic       vis0,
    output logic       hs0,
    output logic       vs0,
    output logic       last0,
    output logic       vblank
);

    localparam cnt_t LAST_H = cnt_t'(2 * FB_W - 1);
    localparam cnt_t LAST_V = cnt_t'(2 * FB_H - 1);

    cnt_t h_q;
    cnt_t v_q;
    logic h_last;
    logic v_last;

    assign h_last = (h_q == H_TOTAL - 1'b1);
    assign v_last = (v_q == V_TOTAL - 1'b1);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            h_q    <= '0;
            v_q    <= '0;
            vblank <= 1'b0;
        end else begin
            h_q <= h_last ? '0 : h_q + 1'b1;
            if (h_last)
                v_q <= v_last ? '0 : v_q + 1'b1;
            vblank <= (v_q >= V_VIS);
        end
    end

    assign x0    = h_q[9:1];
    assign y0    = v_q[8:1];
    assign bar0  = h_q[9:7];
    assign vis0  = (h_q < H_VIS) && (v_q < V_VIS);
    assign hs0   = !((h_q >= H_SYNC_START) && (h_q < H_SYNC_END));
    assign vs0   = !((v_q >= V_SYNC_START) && (v_q < V_SYNC_END));
    assign last0 = (h_q == LAST_H) && (v_q == LAST_V);

endmodule

// File: rtl/vga_scanout.sv
// vga_scanout: 320x240 frame buffer to 640x480@60 VGA with 2x pixel doubling.
// SCANOUT_TEST_PATTERN_EN: colour bars from h[9:7], no frame-buffer reads.
`timescale 1ns/1ps
module vga_scanout
    import vga_pkg::*;
(
    input  logic                clock,
    input  logic                resetn,
    input  logic [COLOUR_W-1:0] mem_q,
    output logic [ADDR_W-1:0]   mem_address,
    output logic                mem_read,
    output logic [7:0]          vga_r,
    output logic [7:0]          vga_g,
    output logic [7:0]          vga_b,
    output logic                vga_hs,
    output logic                vga_vs,
    output logic                vga_blank_n,
    output logic                vblank,
    output logic                frame_done
);

    fb_x_t      x0;
    fb_y_t      y0;
    logic [2:0] bar0;
    logic       vis0;
    logic       hs0;
    logic       vs0;
    logic       last0;

    vga_timing_gen u_timing (
        .clock  (clock),
        .resetn (resetn),
        .x0     (x0),
        .y0     (y0),
        .bar0   (bar0),
        .vis0   (vis0),
        .hs0    (hs0),
        .vs0    (vs0),
        .last0  (last0),
        .vblank (vblank)
    );

    logic    rd_q;
    sync_t   s1;
    sync_t   s2;
    colour_t pix2;
    rgb_t    rgb2;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rd_q        <= 1'b0;
            mem_address <= '0;
            frame_done  <= 1'b0;
            s1          <= SYNC_IDLE;
        end else begin
            rd_q        <= vis0;
            mem_address <= vis0 ? fb_addr(x0, y0) : '0;
            frame_done  <= last0;
            s1          <= '{vis: vis0, hs: hs0, vs: vs0};
        end
    end

    // mem_q for the stage-1 address lands while s2 holds its timing
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            s2 <= SYNC_IDLE;
        else
            s2 <= s1;
    end

`ifdef SCANOUT_TEST_PATTERN_EN
    logic [2:0] bar1;
    logic [2:0] bar2;
    logic       unused_fb;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            bar1 <= '0;
            bar2 <= '0;
        end else begin
            bar1 <= bar0;
            bar2 <= bar1;
        end
    end

    assign pix2      = {bar2, bar2};
    assign mem_read  = 1'b0;
    assign unused_fb = ^{mem_q, rd_q};
`else
    logic unused_bar;

    assign pix2       = mem_q;
    assign mem_read   = rd_q;
    assign unused_bar = ^bar0;
`endif

    assign rgb2 = s2.vis ? expand(pix2) : '0;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
            vga_hs      <= 1'b1;
            vga_vs      <= 1'b1;
            vga_blank_n <= 1'b0;
        end else begin
            vga_r       <= rgb2.r;
            vga_g       <= rgb2.g;
            vga_b       <= rgb2.b;
            vga_hs      <= s2.hs;
            vga_vs      <= s2.vs;
            vga_blank_n <= s2.vis;
        end
    end

endmodule
